// File: rtl/buzzer_tone_sequencer.sv
// buzzer_tone_sequencer: plays a note table as a square wave on the buzzer pad, with a silent gap after each note.
// Define BUZZER_SEQ_LOOP_EN to repeat the table until stop instead of finishing after one pass.
module buzzer_tone_sequencer #(
  parameter int DEPTH = 16,
  parameter int DIV_W = 20,
  parameter int DUR_W = 12,
  parameter int TICK_DIV = 100000,
  parameter int GAP_TICKS = 10
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic                       tbl_we,
  input  logic [$clog2(DEPTH)-1:0]   tbl_addr,
  input  logic [DIV_W+DUR_W-1:0]     tbl_wdata,
  input  logic [$clog2(DEPTH):0]     num_notes,
  input  logic                       start,
  input  logic                       stop,
  output logic                       buzzer_out,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH)-1:0]   cur_idx
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(TICK_DIV + 1);
`ifdef BUZZER_SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, DONE} state_t;
  state_t state, adv_state;
  logic [DIV_W+DUR_W-1:0] tbl [DEPTH];
  logic [DIV_W+DUR_W-1:0] entry;
  logic [DIV_W-1:0] hp_q, tone_cnt;
  logic [DUR_W-1:0] dur_q, tick_cnt;
  logic [PW-1:0] presc;
  logic [AW:0] num_q;
  logic [AW-1:0] adv_idx;
  logic tick, more, tone_wrap;
  always_ff @(posedge ACLK)
    if (tbl_we) tbl[tbl_addr] <= tbl_wdata;
  assign entry = tbl[cur_idx];
  assign tick = presc == PW'(TICK_DIV - 1);
  assign more = {1'b0, cur_idx} + (AW+1)'(1) < num_q;
  assign tone_wrap = tone_cnt == hp_q - DIV_W'(1);
  // Where to go once a note (or a skipped entry) is finished.
  always_comb begin
    adv_state = (more || LOOP) ? LOAD : DONE;
    adv_idx = more ? cur_idx + AW'(1) : LOOP ? '0 : cur_idx;
  end
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      state <= IDLE;
      buzzer_out <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      cur_idx <= '0;
      hp_q <= '0;
      dur_q <= '0;
      tone_cnt <= '0;
      tick_cnt <= '0;
      presc <= '0;
      num_q <= '0;
    end else if (stop && state != IDLE) begin
      state <= IDLE;
      buzzer_out <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start && !stop) begin
          state <= LOAD;
          busy <= 1'b1;
          num_q <= num_notes;
          cur_idx <= '0;
        end
        LOAD: if (num_q == '0) begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          hp_q <= entry[DUR_W +: DIV_W];
          dur_q <= entry[DUR_W-1:0];
          tone_cnt <= '0;
          tick_cnt <= '0;
          presc <= '0;
          if (entry[DUR_W-1:0] != '0) state <= PLAY;
          else begin
            state <= adv_state;
            cur_idx <= adv_idx;
            busy <= adv_state == LOAD;
            done <= adv_state == DONE;
          end
        end
        PLAY: begin
          presc <= tick ? '0 : presc + PW'(1);
          if (hp_q != '0) begin
            tone_cnt <= tone_wrap ? '0 : tone_cnt + DIV_W'(1);
            if (tone_wrap) buzzer_out <= ~buzzer_out;
          end
          if (tick) tick_cnt <= tick_cnt + DUR_W'(1);
          if (tick && tick_cnt == dur_q - DUR_W'(1)) begin
            state <= GAP;
            buzzer_out <= 1'b0;
            tick_cnt <= '0;
          end
        end
        GAP: begin
          presc <= tick ? '0 : presc + PW'(1);
          if (tick) tick_cnt <= tick_cnt + DUR_W'(1);
          if (tick && tick_cnt == DUR_W'(GAP_TICKS - 1)) begin
            state <= adv_state;
            cur_idx <= adv_idx;
            busy <= adv_state == LOAD;
            done <= adv_state == DONE;
          end
        end
        DONE: begin
          state <= IDLE;
          done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
